router_out_arb: RTL
===================

// Module: router_out_arb
// PURPOSE
// - Output-port allocator and flit mux that sits directly downstream of the combinational route-compute stage.
// - Route-compute raises one request bit per input toward this output port (in_req).
// - This block round-robin arbitrates among the requests and locks the winner for a whole packet (wormhole).
// - It forwards flits through one register stage and tracks downstream buffer credits.
// PARAMETERS
// - NUM_IN   3   number of requesting input ports (2..8)
// - DATA_W   32  flit payload width
// - CREDITS  4   downstream buffer depth = credit count after reset (1..15)
// - CNT_W    4   width of credit_cnt; must hold CREDITS
// PORTS
// - clk          in   1             single clock, all state on rising edge
// - rst_n        in   1             synchronous, active-low reset
// - in_req       in   NUM_IN        route-compute request toward this port, per input
// - in_valid     in   NUM_IN        flit valid, per input
// - in_tail      in   NUM_IN        flit is last of packet, per input
// - in_data      in   NUM_IN*DATA_W flit payloads; input i at [i*DATA_W +: DATA_W]
// - in_ready     out  NUM_IN        flit accepted this cycle, per input (combinational)
// - out_valid    out  1             registered flit valid to downstream
// - out_data     out  DATA_W        registered flit payload
// - out_tail     out  1             registered tail flag
// - credit_in    in   1             one downstream slot freed (pulse per slot)
// - credit_cnt   out  CNT_W         current credits available
// - grant_idx    out  3             index of locked input; valid while locked=1
// - locked       out  1             a packet currently owns the port
// - credit_err   out  1             sticky: credit_in received while credit_cnt==CREDITS
// BEHAVIOUR
// - Reset values (rst_n=0 at a clock edge, sampled synchronously):
//   - outputs: out_valid=0, out_data=0, out_tail=0, locked=0, grant_idx=0, credit_err=0, credit_cnt=CREDITS.
//   - internal: rr_ptr=0, FSM state=IDLE.
// - FSM: IDLE, LOCKED.
//   - IDLE: in_ready=0 for all inputs. If any in_req is set, grant the first requester at or after rr_ptr (circular search). Register grant_idx and go to LOCKED at the next edge. There is no data transfer in the arbitration cycle.
//   - LOCKED: in_ready[grant_idx] = (credit_cnt != 0); all other in_ready are 0. A transfer occurs when in_valid[g] & in_ready[g].
//   - LOCKED transitions: a transfer with in_tail[g]=1 moves to IDLE with rr_ptr = (g+1) mod NUM_IN. Otherwise stay in LOCKED.
//   - in_req of the locked input is ignored while LOCKED. Lock is released only by the tail flit.
// - Datapath:
//   - A transfer loads out_data/out_tail from input g and sets out_valid=1 at the next edge.
//   - With no transfer, out_valid=0 at the next edge; out_data and out_tail hold their values.
//   - Latency: flit accepted at cycle t appears at the output in cycle t+1.
//   - Throughput: one flit per cycle while credits remain.
//   - No backpressure on the output side; credits are the only flow control.
// - Credits:
//   - transfer & !credit_in: credit_cnt-1.
//   - credit_in & !transfer: credit_cnt+1.
//   - Both in the same cycle: unchanged.
//   - credit_in arriving in cycle t cannot enable a transfer in cycle t; it takes effect from t+1.
//   - credit_in while credit_cnt==CREDITS and no transfer: count saturates and credit_err is set (sticky until reset).
//   - credit_cnt never underflows, because in_ready gates on credit_cnt != 0.
// - Packet-level rules:
//   - A single-flit packet (head = tail) is legal: lock for one transfer cycle, then return to IDLE.
//   - In_req deasserting while a grant is pending in IDLE does not cancel it. The block enters LOCKED and waits for flits.
//   - Reset asserted mid-packet aborts it:
//     - lock dropped;
//     - out_valid=0 next cycle;
//     - credits restored to CREDITS.
//     - Upstream is responsible for flushing the aborted packet.
// CONFIGURATION
// - ROUTER_ARB_STATS_EN
//   - Defined: adds output pkt_cnt [15:0]. pkt_cnt increments on each tail-flit transfer, wraps 0xFFFF->0, and is reset to 0.
//   - Undefined: no pkt_cnt port and no counter logic; all other behaviour is identical.
// TESTING
// - Reset, then idle 5 cycles:
//   - in_ready=0, out_valid=0, credit_cnt=4, locked=0.
// - in_req=3'b001, 3-flit packet on input 0 (data 0xA0,0xA1,0xA2, tail on last):
//   - grant_idx=0 one cycle after the request.
//   - out_data A0/A1/A2 on consecutive cycles.
//   - credit_cnt 4->1; IDLE after tail; rr_ptr=1.
// - in_req=3'b111 held, 1-flit packets, credit_in pulsed every cycle:
//   - grants cycle 0,1,2,0,...
//   - credit_cnt stays 4 on transfer cycles.
// - No credit_in, 6-flit packet on input 2:
//   - 4 flits pass; in_ready[2]=0 with credit_cnt=0.
//   - credit_in pulse at cycle t -> flit 5 accepted at t+1.
// - Issue credit_in while credit_cnt=4:
//   - credit_err=1 and stays 1; credit_cnt stays 4.
// - Assert rst_n=0 after flit 2 of a packet:
//   - next cycle locked=0, out_valid=0, credit_cnt=4.
//   - With ROUTER_ARB_STATS_EN defined, pkt_cnt=0.

Source files
------------

// File: rtl/router_out_arb_if.sv
// -----------------------------------------------------------------------------
// router_out_arb_if
// Bundles the per-input request/flit/ready signals, the registered output flit,
// and the credit/status signals of one router output port.
//
// Modports:
//   slave  - the arbiter (router_out_arb): consumes requests, flits, credit_in;
//            produces in_ready, the output flit and status.
//   master - the surrounding logic (route compute, input buffers, downstream).
//
// Optional: ROUTER_ARB_STATS_EN adds pkt_cnt[15:0] (completed-packet counter).
// -----------------------------------------------------------------------------
interface router_out_arb_if #(
  parameter int NUM_IN = 3,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 4
);
  logic [NUM_IN-1:0]        in_req;
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN-1:0]        in_tail;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_tail;
  logic                     credit_in;
  logic [CNT_W-1:0]         credit_cnt;
  logic [2:0]               grant_idx;
  logic                     locked;
  logic                     credit_err;
`ifdef ROUTER_ARB_STATS_EN
  logic [15:0]              pkt_cnt;
`endif

  modport slave (
    input  in_req, in_valid, in_tail, in_data, credit_in,
    output in_ready, out_valid, out_data, out_tail,
           credit_cnt, grant_idx, locked, credit_err
`ifdef ROUTER_ARB_STATS_EN
  , output pkt_cnt
`endif
  );

  modport master (
    output in_req, in_valid, in_tail, in_data, credit_in,
    input  in_ready, out_valid, out_data, out_tail,
           credit_cnt, grant_idx, locked, credit_err
`ifdef ROUTER_ARB_STATS_EN
  , input  pkt_cnt
`endif
  );
endinterface

// File: rtl/router_out_arb.sv
// -----------------------------------------------------------------------------
// router_out_arb
// Output-port allocator and flit mux. Round-robin arbitrates among the inputs
// requesting this port, locks the winner for a whole packet (wormhole), forwards
// its flits through one register stage and tracks downstream buffer credits.
//
// Ports:
//   clk    - single clock, all state on the rising edge
//   rst_n  - synchronous active-low reset
//   bus    - router_out_arb_if.slave:
//            in_req/in_valid/in_tail/in_data (per input), in_ready (comb),
//            out_valid/out_data/out_tail (registered), credit_in, credit_cnt,
//            grant_idx/locked (current owner), credit_err (sticky overflow)
//
// Optional: define ROUTER_ARB_STATS_EN to add pkt_cnt[15:0], a wrapping count
// of tail-flit transfers.
// -----------------------------------------------------------------------------
module router_out_arb #(
  parameter int NUM_IN  = 3,   // 2..8
  parameter int DATA_W  = 32,
  parameter int CREDITS = 4,   // 1..15
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  router_out_arb_if.slave   bus
);

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  localparam logic [CNT_W-1:0] CRED_MAX = CNT_W'(CREDITS);
  localparam logic [2:0]       LAST_IN  = 3'(NUM_IN - 1);

  state_t              state;
  logic [2:0]          rr_ptr;
  logic [2:0]          grant_idx;
  logic                locked;
  logic [CNT_W-1:0]    credit_cnt;
  logic                credit_err;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_tail;
`ifdef ROUTER_ARB_STATS_EN
  logic [15:0]         pkt_cnt;
`endif

  // Combinational arbitration and flit selection
  logic [2*NUM_IN-1:0] req_rot;   // requests rotated so rr_ptr sits at bit 0
  logic                found;
  logic [3:0]          pick;
  logic [NUM_IN-1:0]   ready;
  logic                xfer;
  logic                sel_tail;
  logic [DATA_W-1:0]   sel_data;

  always_comb begin
    // NOTE: every signal driven here gets a default before any conditional
    // assignment; a path that left one unassigned would infer a latch.
    req_rot  = {bus.in_req, bus.in_req} >> rr_ptr;
    found    = 1'b0;
    pick     = '0;
    ready    = '0;
    xfer     = 1'b0;
    sel_tail = 1'b0;
    sel_data = '0;

    // First requester at or after rr_ptr, wrapping around.
    for (int k = 0; k < NUM_IN; k++) begin
      if (!found && req_rot[k]) begin
        found = 1'b1;
        pick  = 4'(rr_ptr) + 4'(k);
        if (pick >= 4'(NUM_IN)) pick = pick - 4'(NUM_IN);
      end
    end

    // Only the owner may send, and only while a downstream slot is free.
    // A credit arriving this cycle is not counted until the next one.
    for (int i = 0; i < NUM_IN; i++) begin
      ready[i] = (state == S_LOCKED) && (credit_cnt != '0) && (grant_idx == 3'(i));
      if (ready[i] && bus.in_valid[i]) begin
        xfer     = 1'b1;
        sel_tail = bus.in_tail[i];
        sel_data = bus.in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      grant_idx  <= '0;
      locked     <= 1'b0;
      credit_cnt <= CRED_MAX;
      credit_err <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tail   <= 1'b0;
`ifdef ROUTER_ARB_STATS_EN
      pkt_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          // A grant, once made, stands even if in_req drops next cycle.
          if (found) begin
            grant_idx <= pick[2:0];
            locked    <= 1'b1;
            state     <= S_LOCKED;
          end
        end
        S_LOCKED: begin
          // Only the tail flit releases the port; in_req is ignored here.
          if (xfer && sel_tail) begin
            locked <= 1'b0;
            state  <= S_IDLE;
            rr_ptr <= (grant_idx == LAST_IN) ? 3'd0 : grant_idx + 3'd1;
`ifdef ROUTER_ARB_STATS_EN
            pkt_cnt <= pkt_cnt + 16'd1;
`endif
          end
        end
        default: state <= S_IDLE;
      endcase

      // Output register: payload holds when no flit moves.
      out_valid <= xfer;
      if (xfer) begin
        out_data <= sel_data;
        out_tail <= sel_tail;
      end

      // Credit accounting; a simultaneous send and return cancel out.
      if (xfer && !bus.credit_in) begin
        credit_cnt <= credit_cnt - 1'b1;
      end else if (bus.credit_in && !xfer) begin
        if (credit_cnt == CRED_MAX) credit_err <= 1'b1;
        else                        credit_cnt <= credit_cnt + 1'b1;
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.out_tail   = out_tail;
  assign bus.credit_cnt = credit_cnt;
  assign bus.grant_idx  = grant_idx;
  assign bus.locked     = locked;
  assign bus.credit_err = credit_err;
`ifdef ROUTER_ARB_STATS_EN
  assign bus.pkt_cnt    = pkt_cnt;
`endif

endmodule
